// File: rtl/parity_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parity_pkg : shared state encoding and parity-sense constants      |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package parity_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/parity_reduce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parity_reduce : combinational XOR reduction of one WIDTH-bit word  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule
`default_nettype wire

// File: rtl/parity_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parity_stream : per-frame parity generator / checker on a stream   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module parity_stream
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ODD       = 0,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             check_mode,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BEATS);
  localparam logic             PAR_SENSE = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_t           state;
  logic             acc;
  logic             first;
  logic             mode;
  logic             overflow;
  logic [CNT_W-1:0] count;

  logic             word_par;
  logic             beat;
  logic             at_max;
  logic             final_par;
  logic             frame_mode;
  logic [CNT_W-1:0] count_nxt;

  parity_reduce #(.WIDTH(WIDTH)) u_reduce (
    .data   (in_data),
    .parity (word_par)
  );

  assign in_ready   = (state == ST_ACCUM);
  assign out_valid  = (state == ST_RESULT);
  assign beat       = in_valid && in_ready;
  assign at_max     = (count == MAX_CNT);
  assign count_nxt  = at_max ? count : count + CNT_W'(1);
  assign final_par  = acc ^ word_par ^ PAR_SENSE;
  // A single-beat frame has no latched mode yet, so take it straight from the port.
  assign frame_mode = first ? check_mode : mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ACCUM;
      acc          <= 1'b0;
      count        <= '0;
      overflow     <= 1'b0;
      first        <= 1'b1;
      mode         <= 1'b0;
      out_parity   <= 1'b0;
      out_error    <= 1'b0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (beat) begin
            if (in_last) begin
              out_parity   <= final_par;
              out_error    <= frame_mode & (final_par != in_par);
              out_count    <= count_nxt;
              out_overflow <= overflow | at_max;
              state        <= ST_RESULT;
            end else begin
              acc      <= acc ^ word_par;
              count    <= count_nxt;
              overflow <= overflow | at_max;
              first    <= 1'b0;
              if (first) mode <= check_mode;
            end
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            state    <= ST_ACCUM;
            acc      <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            first    <= 1'b1;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire
